// File: rtl/multi_link_message_handler_if.sv
// Handshake bundle for multi_link_message_handler: GT rx/tx, link
// border streams, control streams and status; slave = hub, master = env.
interface multi_link_message_handler_if #(
  parameter int NUM_LINKS    = 2,
  parameter int GT_FIFO_SIZE = 64
);
  logic [GT_FIFO_SIZE-1:0]           in_data;
  logic                              in_valid;
  logic                              in_ready;
  logic [GT_FIFO_SIZE-1:0]           out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_LINKS*GT_FIFO_SIZE-1:0] link_in_data;
  logic [NUM_LINKS-1:0]              link_in_valid;
  logic [NUM_LINKS-1:0]              link_in_ready;
  logic [NUM_LINKS*GT_FIFO_SIZE-1:0] link_out_data;
  logic [NUM_LINKS-1:0]              link_out_valid;
  logic [NUM_LINKS-1:0]              link_out_ready;
  logic [8*NUM_LINKS-1:0]            link_dest_id;
  logic [GT_FIFO_SIZE-1:0]           control_to_handler_data;
  logic                              control_to_handler_valid;
  logic                              control_to_handler_ready;
  logic [GT_FIFO_SIZE-1:0]           handler_to_control_data;
  logic                              handler_to_control_valid;
  logic                              handler_to_control_ready;
  logic                              router_busy;
  logic                              route_error;
`ifdef MSG_HANDLER_STATS_EN
  logic [16*NUM_LINKS-1:0]           tx_count;
  logic [16*NUM_LINKS-1:0]           rx_count;
  logic [15:0]                       drop_count;
`endif

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready,
    input  link_in_data, link_in_valid,
    output link_in_ready,
    output link_out_data, link_out_valid,
    input  link_out_ready,
    input  link_dest_id,
    input  control_to_handler_data, control_to_handler_valid,
    output control_to_handler_ready,
    output handler_to_control_data, handler_to_control_valid,
    input  handler_to_control_ready,
    output router_busy, route_error
`ifdef MSG_HANDLER_STATS_EN
    , output tx_count, rx_count, drop_count
`endif
  );

  modport master (
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready,
    output link_in_data, link_in_valid,
    input  link_in_ready,
    input  link_out_data, link_out_valid,
    output link_out_ready,
    output link_dest_id,
    output control_to_handler_data, control_to_handler_valid,
    input  control_to_handler_ready,
    input  handler_to_control_data, handler_to_control_valid,
    output handler_to_control_ready,
    input  router_busy, route_error
`ifdef MSG_HANDLER_STATS_EN
    , input tx_count, rx_count, drop_count
`endif
  );
endinterface

// File: rtl/multi_link_message_handler.sv
// Per-FPGA message hub: RR egress of links+control to GT, tag/dir ingress dispatch.
// Ports: clk, reset (async active-low), bus (slave modport of the _if).
// Option MSG_HANDLER_STATS_EN adds tx_count/rx_count/drop_count on bus.
module multi_link_message_handler #(
  parameter int         NUM_LINKS    = 2,
  parameter int         GT_FIFO_SIZE = 64,
  parameter int         FIFO_TAG_MSB = 55,
  parameter int         FIFO_TAG_LSB = 48,
  parameter int         DIR_LSB      = 56,
  parameter logic [7:0] CTRL_TAG     = 8'hFF
) (
  input logic                         clk,
  input logic                         reset,
  multi_link_message_handler_if.slave bus
);
  localparam int NR    = NUM_LINKS + 1;
  localparam int PW    = $clog2(NR);
  localparam int DIR_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
  localparam int GT    = GT_FIFO_SIZE;

  // Readies stay low until the first edge after reset release.
  logic r_run;

  logic [NUM_LINKS-1:0][GT-1:0] w_li_data;
  assign w_li_data = bus.link_in_data;

  // ---------------- egress ----------------
  logic [NR-1:0] w_req;
  logic          w_found;
  logic          w_eg_load;
  logic          w_eg_fire;
  logic [PW-1:0] w_gnt;
  logic [PW-1:0] w_rr_nxt;
  logic [PW-1:0] r_rr;
  logic [GT-1:0] w_eg_word;
  logic          r_out_valid;
  logic [GT-1:0] r_out_data;

  assign w_req = r_run ?
    {bus.control_to_handler_valid, bus.link_in_valid} : '0;
  assign w_eg_load = !r_out_valid || bus.out_ready;
  assign w_eg_fire = w_eg_load && w_found;

  // Scan downwards so the nearest requester at/after r_rr wins.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = NR - 1; k >= 0; k--) begin
      v_idx = PW'((int'(r_rr) + k) % NR);
      if (w_req[v_idx]) begin
        w_found = 1'b1;
        w_gnt   = v_idx;
      end
    end
  end

  assign w_rr_nxt = (int'(w_gnt) == NR - 1) ? '0 : w_gnt + 1'b1;

  // Link words: dest id into [63:56], then link index into DIR field.
  always_comb begin
    w_eg_word = bus.control_to_handler_data;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (w_gnt == PW'(i)) begin
        w_eg_word = w_li_data[i];
        w_eg_word[63:56] = bus.link_dest_id[i*8 +: 8];
        w_eg_word[DIR_LSB +: DIR_W] = DIR_W'(i);
      end
    end
  end

  always_comb begin
    bus.link_in_ready = '0;
    for (int i = 0; i < NUM_LINKS; i++)
      bus.link_in_ready[i] = w_eg_fire && (w_gnt == PW'(i));
  end
  assign bus.control_to_handler_ready =
    w_eg_fire && (w_gnt == PW'(NUM_LINKS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run       <= 1'b0;
      r_rr        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_eg_load) begin
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_data <= w_eg_word;
          r_rr       <= w_rr_nxt;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  // ---------------- ingress ----------------
  logic [7:0]                   w_tag;
  logic [DIR_W-1:0]             w_dir;
  logic                         w_is_ctrl;
  logic [NUM_LINKS-1:0]         w_lo_sel;
  logic [NUM_LINKS-1:0]         w_lo_free;
  logic                         w_hc_free;
  logic                         w_in_ready;
  logic                         w_in_fire;
  logic                         w_drop;
  logic [NUM_LINKS-1:0]         r_lo_valid;
  logic [NUM_LINKS-1:0][GT-1:0] r_lo_data;
  logic                         r_hc_valid;
  logic [GT-1:0]                r_hc_data;
  logic                         r_route_err;

  assign w_tag     = bus.in_data[FIFO_TAG_MSB:FIFO_TAG_LSB];
  assign w_dir     = bus.in_data[DIR_LSB +: DIR_W];
  assign w_is_ctrl = (w_tag == CTRL_TAG);
  assign w_hc_free = !r_hc_valid || bus.handler_to_control_ready;

  always_comb begin
    w_lo_sel  = '0;
    w_lo_free = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      w_lo_sel[i]  = !w_is_ctrl && (w_dir == DIR_W'(i));
      w_lo_free[i] = !r_lo_valid[i] || bus.link_out_ready[i];
    end
  end

  // Words matching no link are dropped, so always accepted.
  assign w_in_ready = r_run && (w_is_ctrl ? w_hc_free :
                      (|w_lo_sel) ? |(w_lo_sel & w_lo_free) : 1'b1);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_drop     = w_in_fire && !w_is_ctrl && !(|w_lo_sel);
  assign bus.in_ready = w_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo_valid  <= '0;
      r_lo_data   <= '0;
      r_hc_valid  <= 1'b0;
      r_hc_data   <= '0;
      r_route_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        if (w_in_fire && w_lo_sel[i]) begin
          r_lo_valid[i] <= 1'b1;
          r_lo_data[i]  <= bus.in_data;
        end else if (bus.link_out_ready[i]) begin
          r_lo_valid[i] <= 1'b0;
        end
      end
      if (w_in_fire && w_is_ctrl) begin
        r_hc_valid <= 1'b1;
        r_hc_data  <= bus.in_data;
      end else if (bus.handler_to_control_ready) begin
        r_hc_valid <= 1'b0;
      end
      if (w_drop)
        r_route_err <= 1'b1;
    end
  end

  assign bus.link_out_valid           = r_lo_valid;
  assign bus.link_out_data            = r_lo_data;
  assign bus.handler_to_control_valid = r_hc_valid;
  assign bus.handler_to_control_data  = r_hc_data;
  assign bus.route_error              = r_route_err;
  assign bus.router_busy = (|bus.link_in_valid) || r_out_valid ||
                           (|r_lo_valid) || r_hc_valid;

`ifdef MSG_HANDLER_STATS_EN
  logic [NUM_LINKS-1:0][15:0] r_tx_cnt;
  logic [NUM_LINKS-1:0][15:0] r_rx_cnt;
  logic [15:0]                r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        if (w_eg_fire && (w_gnt == PW'(i)) && (r_tx_cnt[i] != 16'hFFFF))
          r_tx_cnt[i] <= r_tx_cnt[i] + 16'd1;
        if (w_in_fire && w_lo_sel[i] && (r_rx_cnt[i] != 16'hFFFF))
          r_rx_cnt[i] <= r_rx_cnt[i] + 16'd1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.tx_count   = r_tx_cnt;
  assign bus.rx_count   = r_rx_cnt;
  assign bus.drop_count = r_drop_cnt;
`endif
endmodule

// File: tb/tb_multi_link_message_handler.sv
// Bench for multi_link_message_handler: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_multi_link_message_handler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multi_link_message_handler_if #(.NUM_LINKS(2), .GT_FIFO_SIZE(64)) bus ();
  multi_link_message_handler_if #(.NUM_LINKS(3), .GT_FIFO_SIZE(64)) bus3 ();

  multi_link_message_handler #(.NUM_LINKS(2)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  multi_link_message_handler #(.NUM_LINKS(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  function automatic logic [63:0] exp_link(logic [7:0] dest, int r,
                                           logic [63:0] d);
    logic [63:0] w;
    w = d;
    w[63:56] = dest;
    w[56] = r[0];
    return w;
  endfunction

  task automatic idle();
    bus.in_data = '0; bus.in_valid = 0; bus.out_ready = 0;
    bus.link_in_data = '0; bus.link_in_valid = '0;
    bus.link_out_ready = '0; bus.link_dest_id = '0;
    bus.control_to_handler_data = '0; bus.control_to_handler_valid = 0;
    bus.handler_to_control_ready = 0;
    bus3.in_data = '0; bus3.in_valid = 0; bus3.out_ready = 0;
    bus3.link_in_data = '0; bus3.link_in_valid = '0;
    bus3.link_out_ready = '0; bus3.link_dest_id = '0;
    bus3.control_to_handler_data = '0; bus3.control_to_handler_valid = 0;
    bus3.handler_to_control_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    bus.link_dest_id = 16'h2110;
    bus.link_in_valid = 2'b11;
    bus.link_in_data = {64'h1, 64'h2};
    bus.control_to_handler_valid = 1;
    bus.in_valid = 1;
    bus.in_data = 64'h00FF_0000_0000_0001;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL rst_preburst out_valid got %b exp 1", bus.out_valid);
    end
    #1 reset = 0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.link_out_valid !== 2'b00) begin
      n_err++; $display("FAIL rst_link_out_valid got %b exp 00", bus.link_out_valid);
    end
    n_cmp++;
    if (bus.handler_to_control_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_hc_valid got %b exp 0", bus.handler_to_control_valid);
    end
    n_cmp++;
    if ({bus.in_ready, bus.link_in_ready, bus.control_to_handler_ready} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_readies got %b%b%b exp 0000", bus.in_ready,
               bus.link_in_ready, bus.control_to_handler_ready);
    end
    n_cmp++;
    if (bus.route_error !== 1'b0) begin
      n_err++; $display("FAIL rst_route_error got %b exp 0", bus.route_error);
    end
    @(negedge clk);
    idle();
    reset = 1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.link_out_valid, bus.handler_to_control_valid} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_release_valids got %b%b%b exp 0000", bus.out_valid,
               bus.link_out_valid, bus.handler_to_control_valid);
    end
  endtask

  task automatic test_rr_order();
    logic [63:0] d[3];
    logic [63:0] e[3];
    int g;
    idle();
    do_reset();
    d[0] = 64'h0011_2233_4455_6601;
    d[1] = 64'h00AA_BBCC_DDEE_FF02;
    d[2] = 64'hAA00_0000_0000_0003;
    e[0] = exp_link(8'h10, 0, d[0]);
    e[1] = exp_link(8'h21, 1, d[1]);
    e[2] = d[2];
    bus.link_dest_id = 16'h2110;
    bus.link_in_data = {d[1], d[0]};
    bus.link_in_valid = 2'b11;
    bus.control_to_handler_data = d[2];
    bus.control_to_handler_valid = 1;
    bus.out_ready = 1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      g = bus.link_in_ready[0] ? 0 : bus.link_in_ready[1] ? 1 :
          bus.control_to_handler_ready ? 2 : -1;
      if (c < 6) begin
        n_cmp++;
        if (g != c % 3) begin
          n_err++; $display("FAIL rr_grant cycle %0d got %0d exp %0d", c, g, c % 3);
        end
      end
      if (c > 0) begin
        n_cmp++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, e[(c-1)%3]}) begin
          n_err++;
          $display("FAIL rr_word cycle %0d got %b/%h exp 1/%h", c,
                   bus.out_valid, bus.out_data, e[(c-1)%3]);
        end
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_rewrite();
    idle();
    bus.link_dest_id = {8'h05, 8'h03};
    bus.link_in_data = '0;
    bus.link_in_valid = 2'b10;
    bus.out_ready = 1;
    #1;
    n_cmp++;
    if (bus.link_in_ready !== 2'b10) begin
      n_err++; $display("FAIL rewrite_ready got %b exp 10", bus.link_in_ready);
    end
    @(negedge clk);
    bus.link_in_valid = 2'b00;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_data[63:56]} !== {1'b1, 8'h05}) begin
      n_err++;
      $display("FAIL rewrite_dest got %b/%h exp 1/05", bus.out_valid, bus.out_data[63:56]);
    end
    n_cmp++;
    if ({bus.out_data[56], bus.out_data[55:0]} !== 57'h100000000000000) begin
      n_err++;
      $display("FAIL rewrite_dir got %b/%h exp 1/0", bus.out_data[56], bus.out_data[55:0]);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_ctrl_backpressure();
    logic [63:0] w1, w2;
    w1 = 64'h12FF_0000_0000_AAAA;
    w2 = 64'h34FF_0000_0000_BBBB;
    idle();
    bus.in_valid = 1;
    bus.in_data = w1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_first_ready got %b exp 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_data = w2;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({bus.handler_to_control_valid, bus.handler_to_control_data, bus.in_ready}
          !== {1'b1, w1, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d got %b/%h/%b exp 1/%h/0", i,
                 bus.handler_to_control_valid, bus.handler_to_control_data,
                 bus.in_ready, w1);
      end
      @(negedge clk);
    end
    bus.handler_to_control_ready = 1;
    #1;
    n_cmp++;
    if ({bus.handler_to_control_valid, bus.handler_to_control_data, bus.in_ready}
        !== {1'b1, w1, 1'b1}) begin
      n_err++;
      $display("FAIL bp_release got %b/%h/%b exp 1/%h/1", bus.handler_to_control_valid,
               bus.handler_to_control_data, bus.in_ready, w1);
    end
    @(negedge clk);
    bus.in_valid = 0;
    #1;
    n_cmp++;
    if ({bus.handler_to_control_valid, bus.handler_to_control_data} !== {1'b1, w2}) begin
      n_err++;
      $display("FAIL bp_second got %b/%h exp 1/%h", bus.handler_to_control_valid,
               bus.handler_to_control_data, w2);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.handler_to_control_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_empty got %b exp 0", bus.handler_to_control_valid);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_route_error();
    idle();
    #1;
    n_cmp++;
    if (bus3.route_error !== 1'b0) begin
      n_err++; $display("FAIL rerr_initial got %b exp 0", bus3.route_error);
    end
    bus3.in_data = 64'h0300_0000_0000_0077;
    bus3.in_valid = 1;
    #1;
    n_cmp++;
    if (bus3.in_ready !== 1'b1) begin
      n_err++; $display("FAIL rerr_drop_ready got %b exp 1", bus3.in_ready);
    end
    @(negedge clk);
    bus3.in_data = 64'h0200_0000_0000_0055;
    #1;
    n_cmp++;
    if ({bus3.link_out_valid, bus3.route_error} !== 4'b0001) begin
      n_err++;
      $display("FAIL rerr_set got %b/%b exp 000/1", bus3.link_out_valid, bus3.route_error);
    end
    @(negedge clk);
    bus3.in_valid = 0;
    #1;
    n_cmp++;
    if ({bus3.link_out_valid, bus3.link_out_data[191:128]}
        !== {3'b100, 64'h0200_0000_0000_0055}) begin
      n_err++;
      $display("FAIL rerr_link2 got %b/%h exp 100/0200000000000055",
               bus3.link_out_valid, bus3.link_out_data[191:128]);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (bus3.route_error !== 1'b1) begin
      n_err++; $display("FAIL rerr_sticky got %b exp 1", bus3.route_error);
    end
`ifdef MSG_HANDLER_STATS_EN
    n_cmp++;
    if (bus3.drop_count !== 16'd1) begin
      n_err++; $display("FAIL rerr_drop_count got %0d exp 1", bus3.drop_count);
    end
`endif
    @(negedge clk);
    idle();
  endtask

  task automatic test_random();
    logic [63:0] q_eg[3][$];
    logic [63:0] q_in[3][$];
    logic        sv[3];
    logic [63:0] sd[3];
    int          sc[3];
    logic        gv;
    logic [63:0] gd;
    int          gc;
    logic        hold;
    logic [63:0] hold_d;
    logic        drain;
    int          rx, cyc, s, dst;
    bit          done;
    idle();
    do_reset();
    bus.link_dest_id = 16'h2110;
    for (int k = 0; k < 3; k++) begin sv[k] = 0; sd[k] = '0; sc[k] = 0; end
    gv = 0; gd = '0; gc = 0; hold = 0; hold_d = '0;
    rx = 0; cyc = 0; done = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (!sv[k] && sc[k] < 250 && $urandom_range(0, 3) != 0) begin
          sd[k] = {$urandom, $urandom};
          if (k == 2) sd[k][63:56] = 8'hAA;
          sv[k] = 1;
          sc[k]++;
        end
      end
      if (!gv && gc < 250 && $urandom_range(0, 3) != 0) begin
        gd = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) gd[55:48] = 8'hFF;
        else if (gd[55:48] == 8'hFF) gd[55:48] = 8'h00;
        gv = 1;
        gc++;
      end
      bus.link_in_valid = {sv[1], sv[0]};
      bus.link_in_data = {sd[1], sd[0]};
      bus.control_to_handler_valid = sv[2];
      bus.control_to_handler_data = sd[2];
      bus.in_valid = gv;
      bus.in_data = gd;
      drain = (sc[0] == 250) && (sc[1] == 250) && (sc[2] == 250) && (gc == 250);
      bus.out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
      bus.link_out_ready = drain ? 2'b11 : 2'($urandom_range(0, 3));
      bus.handler_to_control_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (hold) begin
        n_cmp++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, hold_d}) begin
          n_err++;
          $display("FAIL rnd_out_stable got %b/%h exp 1/%h", bus.out_valid,
                   bus.out_data, hold_d);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        s = (bus.out_data[63:56] == 8'h10) ? 0 : (bus.out_data[63:56] == 8'h21) ? 1 :
            (bus.out_data[63:56] == 8'hAA) ? 2 : -1;
        n_cmp++;
        rx++;
        if (s < 0 || q_eg[s].size() == 0) begin
          n_err++; $display("FAIL rnd_egress_unexpected got %h exp none", bus.out_data);
        end else begin
          if (bus.out_data !== q_eg[s][0]) begin
            n_err++;
            $display("FAIL rnd_egress src %0d got %h exp %h", s, bus.out_data, q_eg[s][0]);
          end
          void'(q_eg[s].pop_front());
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      for (int k = 0; k < 2; k++) begin
        if (bus.link_out_valid[k] && bus.link_out_ready[k]) begin
          n_cmp++;
          rx++;
          if (q_in[k].size() == 0) begin
            n_err++;
            $display("FAIL rnd_ingress_unexpected link %0d got %h exp none", k,
                     bus.link_out_data[k*64 +: 64]);
          end else begin
            if (bus.link_out_data[k*64 +: 64] !== q_in[k][0]) begin
              n_err++;
              $display("FAIL rnd_ingress link %0d got %h exp %h", k,
                       bus.link_out_data[k*64 +: 64], q_in[k][0]);
            end
            void'(q_in[k].pop_front());
          end
        end
      end
      if (bus.handler_to_control_valid && bus.handler_to_control_ready) begin
        n_cmp++;
        rx++;
        if (q_in[2].size() == 0) begin
          n_err++;
          $display("FAIL rnd_ctrl_unexpected got %h exp none", bus.handler_to_control_data);
        end else begin
          if (bus.handler_to_control_data !== q_in[2][0]) begin
            n_err++;
            $display("FAIL rnd_ctrl got %h exp %h", bus.handler_to_control_data, q_in[2][0]);
          end
          void'(q_in[2].pop_front());
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (sv[k] && bus.link_in_ready[k]) begin
          q_eg[k].push_back(exp_link(k == 0 ? 8'h10 : 8'h21, k, sd[k]));
          sv[k] = 0;
        end
      end
      if (sv[2] && bus.control_to_handler_ready) begin
        q_eg[2].push_back(sd[2]);
        sv[2] = 0;
      end
      if (gv && bus.in_ready) begin
        dst = (gd[55:48] == 8'hFF) ? 2 : int'(gd[56]);
        q_in[dst].push_back(gd);
        gv = 0;
      end
      done = drain && !sv[0] && !sv[1] && !sv[2] && !gv &&
             q_eg[0].size() == 0 && q_eg[1].size() == 0 && q_eg[2].size() == 0 &&
             q_in[0].size() == 0 && q_in[1].size() == 0 && q_in[2].size() == 0;
    end
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL rnd_timeout got cycles %0d exp completion", cyc);
    end
    n_cmp++;
    if (rx != 1000) begin
      n_err++; $display("FAIL rnd_delivered got %0d exp 1000", rx);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_rr_order();
    test_rewrite();
    test_ctrl_backpressure();
    test_route_error();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
